cbus_arbiter: RTL and testbench
===============================

// Module: cbus_arbiter
// PURPOSE
//  Shares the single cache-bus master port (the cbus_req_t/cbus_resp_t pair feeding the CBus-to-AXI
//  converter) among NUM_INPUTS requesters, e.g. instruction fetch and data memory in VTop.
//  Round-robin arbitration; a grant is held for a whole transaction, including every burst beat.
//  Responses are routed only to the granted requester. Sits between core-side buses and CBusToAXI.
// PARAMETERS
//  NUM_INPUTS  2  number of requester ports (2..8)
// PORTS
//  clk      in   1                     clock; all state updates on posedge
//  resetn   in   1                     synchronous, active-low reset
//  ireqs    in   cbus_req_t[NUM_INPUTS]  requester requests (valid,is_write,size,addr,strobe,data,len)
//  iresps   out  cbus_resp_t[NUM_INPUTS] per-requester responses (ready,last,data)
//  oreq     out  cbus_req_t            request to CBusToAXI
//  oresp    in   cbus_resp_t           response from CBusToAXI
//  grant_idx out $clog2(NUM_INPUTS)    index of current/last grantee (debug)
//  busy     out  1                     1 while a transaction is granted
// BEHAVIOUR
//  State: busy (1b), sel (index), ptr (round-robin pointer). Reset (resetn=0 at posedge):
//   busy=0, sel=0, ptr=0. Therefore oreq='0, every iresps[i]='0, grant_idx=0.
//  IDLE (busy=0):
//   - oreq='0 and all iresps='0, driven combinationally from busy.
//   - If any ireqs[i].valid, choose the first valid index scanning ptr, ptr+1, ... modulo NUM_INPUTS.
//     Next edge: busy<=1, sel<=chosen. Latency: valid at cycle T -> oreq.valid at T+1.
//  BUSY (busy=1):
//   - oreq = ireqs[sel] verbatim. iresps[sel] = oresp; iresps[j!=sel] = '0.
//   - A beat completes on each cycle with oresp.ready=1. The transaction ends on the cycle with
//     oresp.ready && oresp.last; next edge: busy<=0, ptr<=(sel+1) mod NUM_INPUTS.
//   - New requests are never granted in the cycle a transaction ends, so there is a one-cycle IDLE
//     bubble between transactions. Non-granted requesters see ready=0 and keep waiting.
//   - The arbiter ignores len. Beat count is set by oresp.last only.
//  Requester rules: hold valid and all fields stable from assertion until ready&&last. Dropping
//   valid mid-transaction is illegal. The arbiter does not check it and stays BUSY until last.
//  ptr changes only at transaction end. Modulo wrap: sel=NUM_INPUTS-1 gives ptr=0.
//  Reset mid-transaction: at the reset edge busy goes to 0, so oreq.valid=0 from the next cycle.
//   The downstream converter shares resetn and aborts too. No response is replayed.
//  oresp.ready while IDLE is ignored and is not forwarded.
//  Purely synchronous. No combinational path from ireqs to oreq in the same cycle except through
//   ireqs[sel] in BUSY. grant_idx=sel.
// TESTING
//  1. Single read: ireqs[1] valid read addr 0x1fc0_0000, len=0; downstream ready+last at T+3.
//     Expect oreq.valid=1 at T+1..T+3, iresps[1].ready=1 only at T+3, busy=0 at T+4, ptr=0.
//  2. Contention: ireqs[0] and ireqs[1] both valid at T, ptr=0. Expect grant 0 first, then one idle
//     cycle, then grant 1. iresps[1] stays '0 throughout grant 0.
//  3. Burst: ireqs[0] read len=3, 4 ready beats with last on the 4th. Expect four iresps[0].ready
//     pulses carrying data 0xA0..0xA3, grant held for all beats; ireqs[1] waits.
//  4. Fairness, NUM_INPUTS=3: all three valid continuously. Expect grant order 0,1,2,0,1,2 and
//     ptr wraps 2->0.
//  5. Reset mid-burst: resetn=0 after the 2nd of 4 beats. Expect oreq='0 and all iresps='0 from the
//     next cycle, busy=0, ptr=0. After reset release, a pending ireqs[1] is granted fresh.
//  6. Spurious oresp.ready=1, last=1 while IDLE. Expect no iresps pulse and no state change.

Source files
------------

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cache-bus master port among requesters.
// Grant is held for a whole transaction; responses go to the grantee only.
`timescale 1ns/1ps

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   ireqs / iresps       per-requester request in / response out
//   oreq / oresp         shared port towards CBusToAXI
//   grant_idx            current/last grantee index (debug)
//   busy                 high while a transaction is granted
module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  cbus_req_t            ireqs [NUM_INPUTS],
  output cbus_resp_t           iresps [NUM_INPUTS],
  output cbus_req_t            oreq,
  input  cbus_resp_t           oresp,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
  output logic                 busy
);

  localparam int IW = $clog2(NUM_INPUTS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] sel;
  logic [IW-1:0] sel_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] pick;
  logic          found;
  logic [IW:0]   scan;
  logic          txn_end;

  // First valid requester scanning from ptr, wrapping modulo NUM_INPUTS.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    scan  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      scan = {1'b0, ptr} + (IW+1)'(i);
      if (scan >= (IW+1)'(NUM_INPUTS)) begin
        scan = scan - (IW+1)'(NUM_INPUTS);
      end
      if (!found && ireqs[scan[IW-1:0]].valid) begin
        found = 1'b1;
        pick  = scan[IW-1:0];
      end
    end
  end

  assign txn_end = oresp.ready && oresp.last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // No grant on the ending cycle: BUSY always returns through IDLE.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = BUSY;
          sel_nxt   = pick;
        end
      end
      BUSY: begin
        if (txn_end) begin
          state_nxt = IDLE;
          if (sel == IW'(NUM_INPUTS - 1)) begin
            ptr_nxt = '0;
          end else begin
            ptr_nxt = sel + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy      = (state == BUSY);
  assign grant_idx = sel;

  always_comb begin
    oreq = '0;
    if (busy) begin
      oreq = ireqs[sel];
    end
  end

  // Idle-time oresp activity is never forwarded.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (busy && sel == IW'(i)) begin
        iresps[i] = oresp;
      end
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter with three requesters.
// Stimulus queues expected grants/beats; a negedge monitor checks them.
`timescale 1ns/1ps

module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam int N = 3;

  logic       clk;
  logic       resetn;
  cbus_req_t  ireqs [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic [1:0] grant_idx;
  logic       busy;

  cbus_arbiter #(.NUM_INPUTS(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] addr;
  } gexp_t;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] data;
    logic        last;
  } bexp_t;

  gexp_t gq [$];
  bexp_t bq [$];
  int    vecs = 0;
  int    errs = 0;

  logic  mon_en = 1'b0;
  logic  busy_q = 1'b0;
  logic  end_q  = 1'b0;
  int    cur    = 0;
  gexp_t g;
  bexp_t e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (end_q) begin
        vecs++;
        if (busy !== 1'b0) begin
          errs++;
          $display("FAIL end_to_idle busy=%b want 0", busy);
        end
      end
      if (busy === 1'b1 && !busy_q) begin
        vecs++;
        if (gq.size() == 0) begin
          errs++;
          $display("FAIL grant_unexpected idx=%0d want none", grant_idx);
        end else begin
          g   = gq.pop_front();
          cur = int'(g.idx);
          if (grant_idx !== g.idx || oreq.addr !== g.addr ||
              oreq.valid !== 1'b1) begin
            errs++;
            $display("FAIL grant idx=%0d addr=%h v=%b want idx=%0d addr=%h v=1",
                     grant_idx, oreq.addr, oreq.valid, g.idx, g.addr);
          end
        end
      end
      vecs++;
      if (busy === 1'b1) begin
        if (oreq !== ireqs[cur]) begin
          errs++;
          $display("FAIL oreq_pass got=%h want=%h", oreq, ireqs[cur]);
        end
      end else if (oreq !== '0) begin
        errs++;
        $display("FAIL idle_oreq got=%h want 0", oreq);
      end
      for (int k = 0; k < N; k++) begin
        vecs++;
        if (busy !== 1'b1 || k != cur) begin
          if (iresps[k] !== '0) begin
            errs++;
            $display("FAIL resp_leak port=%0d got=%h want 0", k, iresps[k]);
          end
        end else begin
          if (iresps[k] !== oresp) begin
            errs++;
            $display("FAIL resp_route port=%0d got=%h want=%h",
                     k, iresps[k], oresp);
          end
          if (iresps[k].ready === 1'b1) begin
            vecs++;
            if (bq.size() == 0) begin
              errs++;
              $display("FAIL beat_unexpected port=%0d data=%h", k,
                       iresps[k].data);
            end else begin
              e = bq.pop_front();
              if (e.idx !== 2'(k) || e.data !== iresps[k].data ||
                  e.last !== iresps[k].last) begin
                errs++;
                $display("FAIL beat port=%0d data=%h last=%b want port=%0d data=%h last=%b",
                         k, iresps[k].data, iresps[k].last,
                         e.idx, e.data, e.last);
              end
            end
          end
        end
      end
      busy_q = (busy === 1'b1);
      end_q  = (busy === 1'b1) && oresp.ready && oresp.last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic wr,
                         input logic [31:0] addr, input logic [7:0] len);
    ireqs[idx].valid    = 1'b1;
    ireqs[idx].is_write = wr;
    ireqs[idx].size     = 3'd2;
    ireqs[idx].addr     = addr;
    ireqs[idx].strobe   = wr ? 4'hf : 4'h0;
    ireqs[idx].data     = addr ^ 32'h5a5a_5a5a;
    ireqs[idx].len      = len;
  endtask

  task automatic push_grant(input int idx, input logic [31:0] addr);
    gexp_t x;
    x.idx  = 2'(idx);
    x.addr = addr;
    gq.push_back(x);
  endtask

  task automatic txn(input int idx, input int nbeats,
                     input logic [31:0] base, input int gap,
                     input bit drop);
    bexp_t x;
    for (int b = 0; b < nbeats; b++) begin
      oresp = '0;
      repeat (gap) tick();
      oresp.ready = 1'b1;
      oresp.last  = (b == nbeats - 1);
      oresp.data  = base + 32'(b);
      x.idx  = 2'(idx);
      x.data = base + 32'(b);
      x.last = (b == nbeats - 1);
      bq.push_back(x);
      tick();
    end
    oresp = '0;
    if (drop) ireqs[idx].valid = 1'b0;
  endtask

  task automatic chk_idle(input string name);
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL %s busy=%b want 0", name, busy);
    end
  endtask

  initial begin
    resetn = 1'b0;
    oresp  = '0;
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    tick();
    tick();
    mon_en = 1'b1;
    vecs++;
    if (busy !== 1'b0 || grant_idx !== 2'd0 || oreq !== '0) begin
      errs++;
      $display("FAIL reset busy=%b idx=%0d oreq=%h want 0 0 0",
               busy, grant_idx, oreq);
    end
    resetn = 1'b1;
    tick();

    // single read on port 1, ready+last three cycles after valid
    set_req(1, 1'b0, 32'h1fc0_0000, 8'd0);
    push_grant(1, 32'h1fc0_0000);
    tick();
    txn(1, 1, 32'h0000_0011, 2, 1'b1);
    chk_idle("single_done");

    // ptr now 2: ports 0 and 2 contend, 2 wins, then 0
    set_req(0, 1'b0, 32'h0000_1000, 8'd0);
    set_req(2, 1'b1, 32'h0000_2000, 8'd0);
    push_grant(2, 32'h0000_2000);
    push_grant(0, 32'h0000_1000);
    tick();
    txn(2, 1, 32'h0000_0022, 0, 1'b1);
    tick();
    txn(0, 1, 32'h0000_0020, 0, 1'b1);

    // contention from ptr=0: grant 0, bubble, grant 1
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk_idle("reset2");
    set_req(0, 1'b0, 32'h0000_3000, 8'd0);
    set_req(1, 1'b1, 32'h0000_3100, 8'd0);
    push_grant(0, 32'h0000_3000);
    push_grant(1, 32'h0000_3100);
    tick();
    txn(0, 1, 32'h0000_0030, 0, 1'b1);
    chk_idle("bubble");
    tick();
    txn(1, 1, 32'h0000_0031, 0, 1'b1);

    // 4-beat burst on port 0 with wait states, port 1 waits
    set_req(0, 1'b0, 32'h8000_0100, 8'd3);
    set_req(1, 1'b0, 32'h8000_0200, 8'd0);
    push_grant(0, 32'h8000_0100);
    push_grant(1, 32'h8000_0200);
    tick();
    txn(0, 4, 32'h0000_00a0, 1, 1'b1);
    tick();
    txn(1, 1, 32'h0000_0040, 0, 1'b1);

    // fairness: all three valid continuously
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    set_req(0, 1'b0, 32'h0000_5000, 8'd0);
    set_req(1, 1'b0, 32'h0000_5100, 8'd0);
    set_req(2, 1'b0, 32'h0000_5200, 8'd0);
    for (int r = 0; r < 6; r++) begin
      push_grant(r % 3, 32'h0000_5000 + 32'((r % 3) * 256));
    end
    for (int r = 0; r < 6; r++) begin
      tick();
      txn(r % 3, 1, 32'h0000_0050 + 32'(r), 0, 1'b0);
    end
    for (int i = 0; i < N; i++) ireqs[i].valid = 1'b0;

    // reset after two beats of a 4-beat burst
    set_req(0, 1'b0, 32'h0000_6000, 8'd3);
    set_req(1, 1'b0, 32'h0000_6100, 8'd0);
    push_grant(0, 32'h0000_6000);
    tick();
    for (int b = 0; b < 2; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = 1'b0;
      oresp.data  = 32'h0000_00b0 + 32'(b);
      e.idx  = 2'd0;
      e.data = 32'h0000_00b0 + 32'(b);
      e.last = 1'b0;
      bq.push_back(e);
      tick();
    end
    oresp  = '0;
    resetn = 1'b0;
    tick();
    chk_idle("reset_mid");
    resetn = 1'b1;
    ireqs[0].valid = 1'b0;
    push_grant(1, 32'h0000_6100);
    tick();
    txn(1, 1, 32'h0000_00c0, 0, 1'b1);

    // spurious ready+last while idle; ptr stays 2
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 32'hdead_beef;
    tick();
    tick();
    oresp = '0;
    chk_idle("spurious");
    set_req(1, 1'b0, 32'h0000_7100, 8'd0);
    set_req(2, 1'b0, 32'h0000_7200, 8'd0);
    push_grant(2, 32'h0000_7200);
    push_grant(1, 32'h0000_7100);
    tick();
    txn(2, 1, 32'h0000_00d2, 0, 1'b1);
    tick();
    txn(1, 1, 32'h0000_00d1, 0, 1'b1);
    tick();
    tick();

    vecs++;
    if (gq.size() != 0 || bq.size() != 0) begin
      errs++;
      $display("FAIL drain grants_left=%0d beats_left=%0d want 0 0",
               gq.size(), bq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
